// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding and the fetch entry layout used between IF and ID.
package core_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/id_instr_buffer.sv
// IF/ID instruction queue: DEPTH-entry circular buffer of {pc, instr} with valid/ready toward IF,
// stall from ID, flush on control transfer and NOP bubbles when empty.
// Optional feature: define ID_BUF_BYPASS_EN to pass an IF offer straight to the head when empty.
module id_instr_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [31:0]                  pc_if_i,
  input  logic [31:0]                  instr_if_i,
  input  logic                         valid_if_i,
  output logic                         ready_id_o,
  output logic [31:0]                  pc_id_o,
  output logic [31:0]                  instr_id_o,
  output logic                         valid_id_o,
  input  logic                         stall_id_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  core_pkg::fetch_entry_t mem_q [DEPTH];
  core_pkg::fetch_entry_t head;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   last_pc_q;

  logic empty, full, byp, push, pop, wr_en, rd_en;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  // Registered-state only: no path from stall_id_i, even when a pop would free a slot.
  assign ready_id_o = !full;
  assign count_o    = count_q;
  assign head       = mem_q[rd_ptr_q];

  // Head selection, handshake decode and write/read enables.
  always_comb begin
    byp = 1'b0;
`ifdef ID_BUF_BYPASS_EN
    byp = empty && valid_if_i && !flush_i;
`endif
    valid_id_o = !empty || byp;
    if (byp) begin
      pc_id_o    = pc_if_i;
      instr_id_o = instr_if_i;
    end else if (!empty) begin
      pc_id_o    = head.pc;
      instr_id_o = head.instr;
    end else begin
      pc_id_o    = last_pc_q;
      instr_id_o = NOP_INSTR;
    end
    push  = valid_if_i && ready_id_o && !flush_i;
    pop   = valid_id_o && !stall_id_i && !flush_i;
    // A bypassed instruction consumed in the same cycle never lands in storage.
    wr_en = push && !(byp && pop);
    rd_en = pop && !empty;
  end

  // Pointers, occupancy and the last-consumed PC shown while empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
      if (pop) last_pc_q <= pc_id_o;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{pc: pc_if_i, instr: instr_if_i};
    end
  end

endmodule
